// File: rtl/fx2_cmd_reader.sv
// FX2 slave-FIFO OUT-endpoint reader: pops [len][cmd][payload] frames, emits a header
// strobe plus a ready/valid payload stream, and shares the bus through req/gnt.
module fx2_cmd_reader #(
  parameter logic [1:0]  OUT_EP_ADDR = 2'b00,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic       fx2_clk,
  input  logic       reset_n,
  input  logic [2:0] fx2_flags,
  input  logic [7:0] fx2_fd,
  output logic       fx2_slrd,
  output logic       fx2_sloe,
  output logic [1:0] fx2_fifoadr,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_len,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic       frame_err
);

  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_GNT, S_OE, S_RD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          slrd_q, slrd_d;
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic [7:0]    cmd_len_q, cmd_len_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic          pl_valid_q, pl_valid_d;
  logic          pl_last_q, pl_last_d;
  logic          frame_err_q, frame_err_d;

  logic empty_n, out_free, oversize, last_byte, pop;
  logic unused_flags;

  assign unused_flags = ^fx2_flags[2:1];
  assign empty_n   = fx2_flags[0];
  assign out_free  = !pl_valid_q || pl_ready;
  assign oversize  = {1'b0, len_q} > MAX_LEN9;
  assign last_byte = (idx_q != '0) && (idx_q == ({1'b0, len_q} + 9'd1));
  // slrd_q high means the previous cycle was not a pop: limits reads to 1 byte / 2 clocks
  assign pop       = (state_q == S_RD) && empty_n && bus_gnt && slrd_q && out_free;

  always_ff @(posedge fx2_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      slrd_q      <= 1'b1;
      idx_q       <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_len_q   <= '0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slrd_q      <= slrd_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_len_q   <= cmd_len_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slrd_d      = 1'b1;
    idx_d       = idx_q;
    len_d       = len_q;
    tmo_d       = tmo_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_len_d   = cmd_len_q;
    pl_data_d   = pl_data_q;
    pl_valid_d  = pl_valid_q;
    pl_last_d   = pl_last_q;
    frame_err_d = 1'b0;

    if (pl_valid_q && pl_ready) begin
      pl_valid_d = 1'b0;
      pl_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        tmo_d = '0;
        if (empty_n) state_d = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if (bus_gnt) state_d = S_OE;
      end
      S_OE: begin
        state_d = S_RD;
      end
      S_RD: begin
        // losing the grant keeps the frame position and re-enters through OE
        if (!bus_gnt) begin
          state_d = S_WAIT_GNT;
        end else if (pop) begin
          slrd_d = 1'b0;
          tmo_d  = '0;
          if (idx_q == '0) begin
            len_d = fx2_fd;
          end else if (idx_q == 9'd1) begin
            if (!oversize) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = fx2_fd;
              cmd_len_d   = len_q;
            end
          end else if (!oversize) begin
            pl_data_d  = fx2_fd;
            pl_valid_d = 1'b1;
            pl_last_d  = last_byte;
          end
          if (last_byte) begin
            state_d     = S_DONE;
            idx_d       = '0;
            frame_err_d = oversize;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end else if (!empty_n && out_free) begin
          if (tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            tmo_d       = '0;
            state_d     = S_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fx2_slrd    = slrd_q;
  assign fx2_sloe    = !((state_q == S_OE) || (state_q == S_RD));
  assign fx2_fifoadr = OUT_EP_ADDR;
  assign bus_req     = (state_q == S_WAIT_GNT) || (state_q == S_OE) || (state_q == S_RD);
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_len     = cmd_len_q;
  assign pl_data     = pl_data_q;
  assign pl_valid    = pl_valid_q;
  assign pl_last     = pl_last_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_fx2_cmd_reader.sv
// Bench for fx2_cmd_reader: FIFO model feeding frames, frame-level reference model
// producing expected headers/payload/errors, table rows plus directed corner sequences.
module tb_fx2_cmd_reader;

  localparam int TMO  = 100;
  localparam int MAXL = 8;

  logic       fx2_clk = 1'b0;
  logic       reset_n;
  logic [2:0] fx2_flags;
  logic [7:0] fx2_fd;
  logic       fx2_slrd, fx2_sloe, bus_req, bus_gnt;
  logic [1:0] fx2_fifoadr;
  logic       cmd_valid, pl_valid, pl_ready, pl_last, frame_err;
  logic [7:0] cmd_code, cmd_len, pl_data;

  fx2_cmd_reader #(
    .OUT_EP_ADDR(2'b00),
    .MAX_LEN    (MAXL),
    .TIMEOUT    (TMO)
  ) dut (
    .fx2_clk    (fx2_clk),
    .reset_n    (reset_n),
    .fx2_flags  (fx2_flags),
    .fx2_fd     (fx2_fd),
    .fx2_slrd   (fx2_slrd),
    .fx2_sloe   (fx2_sloe),
    .fx2_fifoadr(fx2_fifoadr),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_len    (cmd_len),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_last    (pl_last),
    .frame_err  (frame_err)
  );

  always #5 fx2_clk = ~fx2_clk;

  typedef struct {
    int len; int cmd; int ready_pct; int gnt_pct;
    int exp_hdrs; int exp_err; int exp_pops;
  } vec_t;
  vec_t vecs[9];

  int checks = 0, errors = 0;
  byte unsigned fifo_q[$];
  byte unsigned frame[$];
  logic [15:0]  exp_hdr[$], hdr_seen[$];
  logic [8:0]   exp_pl[$], pl_seen[$];
  int exp_errs = 0, exp_pops = 0, err_seen = 0, pops_seen = 0, viol = 0;
  int cyc = 0, last_slrd_cyc = 0, err_cyc = 0;
  int ready_pct = 100, gnt_pct = 100;
  bit mon_en = 0, slrd_low = 0, prev_slrd_low = 0, prev_gnt = 0, prev_sloe = 1;

  // Observer: records what the DUT emits and flags FIFO-protocol violations
  always @(negedge fx2_clk) begin
    slrd_low = (fx2_slrd === 1'b0);
    if (mon_en) begin
      cyc++;
      if (slrd_low) begin
        pops_seen++;
        last_slrd_cyc = cyc;
        if (prev_slrd_low || !prev_gnt || prev_sloe) viol++;
      end
      if (cmd_valid === 1'b1) hdr_seen.push_back({cmd_code, cmd_len});
      if (pl_valid === 1'b1 && pl_ready) pl_seen.push_back({pl_last, pl_data});
      if (frame_err === 1'b1) begin
        err_seen++;
        err_cyc = cyc;
      end
      if (fx2_fifoadr !== 2'b00) viol++;
    end
    prev_slrd_low = slrd_low;
    prev_gnt      = bus_gnt;
    prev_sloe     = fx2_sloe;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // FIFO advances on the edge that sees slrd low, as the FX2 does
  task automatic tick();
    @(posedge fx2_clk);
    #1;
    if (slrd_low && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fx2_fd    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    fx2_flags = {2'b11, fifo_q.size() != 0};
    pl_ready  = ($urandom_range(0, 99) < ready_pct);
    bus_gnt   = ($urandom_range(0, 99) < gnt_pct);
  endtask

  task automatic make_frame(input int len, input int cmd);
    frame.delete();
    frame.push_back(8'(len));
    frame.push_back(8'(cmd));
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
  endtask

  // Reference model: whole-frame view of what the reader must produce
  task automatic add_frame();
    int n;
    n = frame[0];
    foreach (frame[i]) fifo_q.push_back(frame[i]);
    exp_pops += frame.size();
    if (n > MAXL) begin
      exp_errs++;
    end else begin
      exp_hdr.push_back({frame[1], frame[0]});
      for (int i = 0; i < n; i++) exp_pl.push_back({(i == n - 1), frame[2 + i]});
    end
  endtask

  task automatic clear_all();
    exp_hdr.delete(); hdr_seen.delete(); exp_pl.delete(); pl_seen.delete();
    exp_errs = 0; exp_pops = 0; err_seen = 0; pops_seen = 0; viol = 0;
  endtask

  task automatic wait_done(input string nm);
    int budget;
    budget = 0;
    tick();
    while (!(fifo_q.size() == 0 && !bus_req && fx2_slrd && !pl_valid) && budget < 4000) begin
      tick();
      budget++;
    end
    chk({nm, " completes"}, int'(budget < 4000), 1);
    repeat (3) tick();
  endtask

  task automatic compare_clear(input string nm);
    chk({nm, " hdr count"}, hdr_seen.size(), exp_hdr.size());
    for (int i = 0; i < exp_hdr.size() && i < hdr_seen.size(); i++)
      chk({nm, " hdr"}, int'(hdr_seen[i]), int'(exp_hdr[i]));
    chk({nm, " payload count"}, pl_seen.size(), exp_pl.size());
    for (int i = 0; i < exp_pl.size() && i < pl_seen.size(); i++)
      chk({nm, " payload"}, int'(pl_seen[i]), int'(exp_pl[i]));
    chk({nm, " frame_err count"}, err_seen, exp_errs);
    chk({nm, " pops"}, pops_seen, exp_pops);
    chk({nm, " protocol"}, viol, 0);
    chk({nm, " sloe released"}, int'(fx2_sloe), 1);
    chk({nm, " req released"}, int'(bus_req), 0);
    clear_all();
  endtask

  initial begin
    int budget, p0, stable;
    logic [7:0] d0;

    vecs[0] = '{0,   'h03, 100, 100, 1, 0, 2};
    vecs[1] = '{1,   'h11, 100, 100, 1, 0, 3};
    vecs[2] = '{8,   'h22, 100, 100, 1, 0, 10};
    vecs[3] = '{8,   'h23, 40,  100, 1, 0, 10};
    vecs[4] = '{3,   'h33, 100, 60,  1, 0, 5};
    vecs[5] = '{9,   'h07, 100, 100, 0, 1, 11};
    vecs[6] = '{0,   'h03, 100, 100, 1, 0, 2};
    vecs[7] = '{12,  'h44, 70,  80,  0, 1, 14};
    vecs[8] = '{255, 'h55, 100, 100, 0, 1, 257};

    reset_n = 1'b0; bus_gnt = 1'b0; pl_ready = 1'b1; fx2_flags = 3'b110; fx2_fd = 8'h00;
    repeat (3) tick();
    chk("reset slrd", int'(fx2_slrd), 1);
    chk("reset sloe", int'(fx2_sloe), 1);
    chk("reset fifoadr", int'(fx2_fifoadr), 0);
    chk("reset req", int'(bus_req), 0);
    chk("reset valids", int'({cmd_valid, pl_valid, pl_last, frame_err}), 0);
    chk("reset cmd_code", int'(cmd_code), 0);
    chk("reset cmd_len", int'(cmd_len), 0);
    chk("reset pl_data", int'(pl_data), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    frame = {8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40, 8'h02};
    add_frame();
    wait_done("example");
    compare_clear("example");

    frame = {8'h01, 8'h01, 8'h01};
    add_frame();
    frame = {8'h01, 8'h02, 8'h01};
    add_frame();
    wait_done("back2back");
    compare_clear("back2back");

    // pl_ready held low mid-payload
    make_frame(8, 'h05);
    add_frame();
    budget = 0;
    while (pl_seen.size() < 2 && budget < 200) begin tick(); budget++; end
    chk("stall reach", int'(budget < 200), 1);
    ready_pct = 0;
    repeat (3) tick();
    d0 = pl_data; p0 = pops_seen; stable = 1;
    repeat (18) begin
      tick();
      if (pl_data !== d0 || pl_valid !== 1'b1) stable = 0;
    end
    chk("stall data held", stable, 1);
    chk("stall no pops", pops_seen - p0, 0);
    chk("stall no err", err_seen, 0);
    ready_pct = 100;
    wait_done("stall");
    compare_clear("stall");

    for (int v = 0; v < 9; v++) begin
      ready_pct = vecs[v].ready_pct;
      gnt_pct   = vecs[v].gnt_pct;
      make_frame(vecs[v].len, vecs[v].cmd);
      add_frame();
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d hdrs", v), hdr_seen.size(), vecs[v].exp_hdrs);
      chk($sformatf("vec%0d err", v), err_seen, vecs[v].exp_err);
      chk($sformatf("vec%0d pops", v), pops_seen, vecs[v].exp_pops);
      compare_clear($sformatf("vec%0d", v));
    end
    ready_pct = 100; gnt_pct = 100;

    // Truncated frame: header and one byte stand, then the empty FIFO aborts it
    frame = {8'h05, 8'h04, 8'h00};
    foreach (frame[i]) fifo_q.push_back(frame[i]);
    exp_hdr.push_back(16'h0405);
    exp_pl.push_back(9'h000);
    exp_errs = 1; exp_pops = 3;
    wait_done("timeout");
    // the FIFO completes the last pop on the edge that ends the slrd-low cycle
    chk("timeout latency", err_cyc - last_slrd_cyc - 1, TMO);
    compare_clear("timeout");

    // reset pulse mid-payload
    make_frame(8, 'h02);
    add_frame();
    budget = 0;
    while (pl_seen.size() < 3 && budget < 200) begin tick(); budget++; end
    chk("midreset reach", int'(budget < 200), 1);
    reset_n = 1'b0;
    tick();
    chk("midreset slrd", int'(fx2_slrd), 1);
    chk("midreset sloe", int'(fx2_sloe), 1);
    chk("midreset req", int'(bus_req), 0);
    chk("midreset valids", int'({cmd_valid, pl_valid, pl_last, frame_err}), 0);
    chk("midreset regs", int'({cmd_code, cmd_len, pl_data}), 0);
    reset_n = 1'b1;
    fifo_q.delete();
    clear_all();
    frame = {8'h00, 8'h01};
    add_frame();
    wait_done("after reset");
    compare_clear("after reset");

    ready_pct = 70; gnt_pct = 85;
    for (int b = 0; b < 10; b++) begin
      for (int f = 0; f < 3; f++) begin
        make_frame(int'($urandom_range(0, 11)), int'($urandom_range(0, 255)));
        add_frame();
      end
      wait_done($sformatf("rand%0d", b));
      compare_clear($sformatf("rand%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
